// File: rtl/reorder_buffer_pkg.sv
// Shared constants for the reorder buffer slice.
//   - Station tag codes (ALU adders, load and store buffers) and the
//     reserved "no tag" code TAG_NONE.
//   - ROB_DEPTH / ROB_TAG_W: default entry count and tag width.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 8;
    localparam int ROB_TAG_W = 4;

    localparam logic [3:0] TAG_NONE   = 4'd0;
    localparam logic [3:0] TAG_ADD1   = 4'd1;
    localparam logic [3:0] TAG_ADD2   = 4'd2;
    localparam logic [3:0] TAG_ADD3   = 4'd3;
    localparam logic [3:0] TAG_LOAD1  = 4'd4;
    localparam logic [3:0] TAG_LOAD2  = 4'd5;
    localparam logic [3:0] TAG_LOAD3  = 4'd6;
    localparam logic [3:0] TAG_STORE1 = 4'd7;
    localparam logic [3:0] TAG_STORE2 = 4'd8;
    localparam logic [3:0] TAG_STORE3 = 4'd9;

endpackage

// File: rtl/rob_tag_match.sv
// Result-port tag matcher for the reorder buffer.
// Compares one result port's tag against every entry in parallel and
// flags the entries that are waiting for exactly that tag.
// Ports:
//   valid_i      result port valid
//   tag_i        result port tag (TAG_NONE never matches)
//   busy_i       per-entry busy bits
//   ready_i      per-entry ready bits
//   entry_tag_i  per-entry station tags
//   match_o      one-hot match vector (at most one bit set by construction)
//   hit_o        any entry matched
module rob_tag_match
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int TAG_W = ROB_TAG_W
) (
    input  logic                        valid_i,
    input  logic [TAG_W-1:0]            tag_i,
    input  logic [DEPTH-1:0]            busy_i,
    input  logic [DEPTH-1:0]            ready_i,
    input  logic [DEPTH-1:0][TAG_W-1:0] entry_tag_i,
    output logic [DEPTH-1:0]            match_o,
    output logic                        hit_o
);

    localparam logic [TAG_W-1:0] NONE_T = TAG_W'(TAG_NONE);

    logic port_live;

    always_comb begin
        match_o   = '0;
        port_live = valid_i && (tag_i != NONE_T);
        for (int i = 0; i < DEPTH; i++) begin
            match_o[i] = port_live && busy_i[i] && !ready_i[i] &&
                         (entry_tag_i[i] == tag_i);
        end
        hit_o = |match_o;
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer for the Tomasulo core.
// Allocates one entry per issued instruction, captures out-of-order results
// from the ALU and load/store ports, and retires at most one ready head entry
// per cycle as a CDB broadcast plus register-file write.
// Ports:
//   clk_in, rst_in (sync, active low), rdy_in (pause when low), flush_in
//   alloc_valid/alloc_tag/alloc_rd/alloc_addr  issue request
//   alloc_full                                 count == DEPTH (from registers only)
//   alu_valid/alu_tag/alu_val                  ALU result port
//   lsb_valid/lsb_tag/lsb_val                  load/store result port
//   cdb_active/cdb_tag/cdb_val/cdb_addr        registered broadcast
//   reg_we/reg_rd/reg_val                      registered register-file write
// Handshake: an allocation is taken on any enabled edge where alloc_valid is
// high and alloc_full is low; the issuer must hold off while alloc_full is high.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int TAG_W = ROB_TAG_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             alloc_valid,
    input  logic [TAG_W-1:0] alloc_tag,
    input  logic [4:0]       alloc_rd,
    input  logic [31:0]      alloc_addr,
    output logic             alloc_full,
    input  logic             alu_valid,
    input  logic [TAG_W-1:0] alu_tag,
    input  logic [31:0]      alu_val,
    input  logic             lsb_valid,
    input  logic [TAG_W-1:0] lsb_tag,
    input  logic [31:0]      lsb_val,
    output logic             cdb_active,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [31:0]      cdb_val,
    output logic [31:0]      cdb_addr,
    output logic             reg_we,
    output logic [4:0]       reg_rd,
    output logic [31:0]      reg_val
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [TAG_W-1:0] NONE_T   = TAG_W'(TAG_NONE);

    logic [DEPTH-1:0]            busy_q,  busy_d;
    logic [DEPTH-1:0]            ready_q, ready_d;
    logic [DEPTH-1:0][TAG_W-1:0] tag_q,   tag_d;
    logic [DEPTH-1:0][4:0]       rd_q,    rd_d;
    logic [DEPTH-1:0][31:0]      addr_q,  addr_d;
    logic [DEPTH-1:0][31:0]      val_q,   val_d;
    logic [PTR_W-1:0]            head_q,  head_d;
    logic [PTR_W-1:0]            tail_q,  tail_d;
    logic [CNT_W-1:0]            count_q, count_d;

    logic             cdb_active_q, cdb_active_d;
    logic [TAG_W-1:0] cdb_tag_q,    cdb_tag_d;
    logic [31:0]      cdb_val_q,    cdb_val_d;
    logic [31:0]      cdb_addr_q,   cdb_addr_d;
    logic             reg_we_q,     reg_we_d;
    logic [4:0]       reg_rd_q,     reg_rd_d;

    logic [DEPTH-1:0] alu_match, lsb_match, lsb_take;
    logic             alu_hit, lsb_hit;
    logic             alloc_ok, retire_ok;

    rob_tag_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_alu_match (
        .valid_i     (alu_valid),
        .tag_i       (alu_tag),
        .busy_i      (busy_q),
        .ready_i     (ready_q),
        .entry_tag_i (tag_q),
        .match_o     (alu_match),
        .hit_o       (alu_hit)
    );

    rob_tag_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_lsb_match (
        .valid_i     (lsb_valid),
        .tag_i       (lsb_tag),
        .busy_i      (busy_q),
        .ready_i     (ready_q),
        .entry_tag_i (tag_q),
        .match_o     (lsb_match),
        .hit_o       (lsb_hit)
    );

    assign alloc_full = (count_q == FULL_CNT);

    always_comb begin
        busy_d       = busy_q;
        ready_d      = ready_q;
        tag_d        = tag_q;
        rd_d         = rd_q;
        addr_d       = addr_q;
        val_d        = val_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        cdb_active_d = 1'b0;
        cdb_tag_d    = NONE_T;
        cdb_val_d    = cdb_val_q;
        cdb_addr_d   = cdb_addr_q;
        reg_we_d     = 1'b0;
        reg_rd_d     = reg_rd_q;

        // alloc_full comes from the registered count, so a same-cycle
        // retirement never opens a slot for a same-cycle allocation.
        alloc_ok  = alloc_valid && !alloc_full;
        retire_ok = busy_q[head_q] && ready_q[head_q];

        // When both ports name one entry the ALU value is the one kept.
        lsb_take = lsb_hit ? (lsb_match & ~alu_match) : '0;

        // Captures only touch busy, not-ready entries; the retiring head is
        // ready and the allocated slot is idle, so the three updates below
        // never collide on one entry.
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_hit && alu_match[i]) begin
                ready_d[i] = 1'b1;
                val_d[i]   = alu_val;
            end else if (lsb_take[i]) begin
                ready_d[i] = 1'b1;
                val_d[i]   = lsb_val;
            end
        end

        if (retire_ok) begin
            cdb_active_d    = 1'b1;
            cdb_tag_d       = tag_q[head_q];
            cdb_val_d       = val_q[head_q];
            cdb_addr_d      = addr_q[head_q];
            reg_we_d        = (rd_q[head_q] != 5'd0);
            reg_rd_d        = rd_q[head_q];
            busy_d[head_q]  = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end

        if (alloc_ok) begin
            busy_d[tail_q]  = 1'b1;
            ready_d[tail_q] = 1'b0;
            tag_d[tail_q]   = alloc_tag;
            rd_d[tail_q]    = alloc_rd;
            addr_d[tail_q]  = alloc_addr;
            tail_d          = tail_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(alloc_ok) - CNT_W'(retire_ok);

        // Flush throws away this cycle's allocation, captures and retirement;
        // the data outputs keep their last broadcast values.
        if (flush_in) begin
            busy_d       = '0;
            ready_d      = '0;
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            cdb_active_d = 1'b0;
            cdb_tag_d    = NONE_T;
            cdb_val_d    = cdb_val_q;
            cdb_addr_d   = cdb_addr_q;
            reg_we_d     = 1'b0;
            reg_rd_d     = reg_rd_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy_q       <= '0;
            ready_q      <= '0;
            tag_q        <= '0;
            rd_q         <= '0;
            addr_q       <= '0;
            val_q        <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            cdb_active_q <= 1'b0;
            cdb_tag_q    <= NONE_T;
            cdb_val_q    <= '0;
            cdb_addr_q   <= '0;
            reg_we_q     <= 1'b0;
            reg_rd_q     <= '0;
        end else if (rdy_in) begin
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            tag_q        <= tag_d;
            rd_q         <= rd_d;
            addr_q       <= addr_d;
            val_q        <= val_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            cdb_active_q <= cdb_active_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_val_q    <= cdb_val_d;
            cdb_addr_q   <= cdb_addr_d;
            reg_we_q     <= reg_we_d;
            reg_rd_q     <= reg_rd_d;
        end
    end

    assign cdb_active = cdb_active_q;
    assign cdb_tag    = cdb_tag_q;
    assign cdb_val    = cdb_val_q;
    assign cdb_addr   = cdb_addr_q;
    assign reg_we     = reg_we_q;
    assign reg_rd     = reg_rd_q;
    // The register-file write data is always the broadcast value.
    assign reg_val    = cdb_val_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer: queue-based program-order model checked on
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int DEPTH = 8;
    localparam int TAG_W = 4;

    // ---------------- clock / reset ----------------
    logic             clk_in = 1'b0;
    logic             rst_in = 1'b0;
    logic             rdy_in = 1'b1;
    logic             flush_in = 1'b0;
    logic             alloc_valid = 1'b0;
    logic [TAG_W-1:0] alloc_tag = '0;
    logic [4:0]       alloc_rd = '0;
    logic [31:0]      alloc_addr = '0;
    logic             alloc_full;
    logic             alu_valid = 1'b0;
    logic [TAG_W-1:0] alu_tag = '0;
    logic [31:0]      alu_val = '0;
    logic             lsb_valid = 1'b0;
    logic [TAG_W-1:0] lsb_tag = '0;
    logic [31:0]      lsb_val = '0;
    logic             cdb_active;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_val;
    logic [31:0]      cdb_addr;
    logic             reg_we;
    logic [4:0]       reg_rd;
    logic [31:0]      reg_val;

    always #5 clk_in = ~clk_in;

    reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .flush_in    (flush_in),
        .alloc_valid (alloc_valid),
        .alloc_tag   (alloc_tag),
        .alloc_rd    (alloc_rd),
        .alloc_addr  (alloc_addr),
        .alloc_full  (alloc_full),
        .alu_valid   (alu_valid),
        .alu_tag     (alu_tag),
        .alu_val     (alu_val),
        .lsb_valid   (lsb_valid),
        .lsb_tag     (lsb_tag),
        .lsb_val     (lsb_val),
        .cdb_active  (cdb_active),
        .cdb_tag     (cdb_tag),
        .cdb_val     (cdb_val),
        .cdb_addr    (cdb_addr),
        .reg_we      (reg_we),
        .reg_rd      (reg_rd),
        .reg_val     (reg_val)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Program-order queue of in-flight instructions; front is the oldest.
    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] val;
        bit          ready;
    } ent_t;

    ent_t        m_q[$];
    ent_t        m_e;
    bit          m_full;
    bit          started = 1'b0;
    logic        m_active, m_we;
    logic [3:0]  m_tag;
    logic [31:0] m_val, m_addr;
    logic [4:0]  m_rd;

    initial forever begin
        @(posedge clk_in);
        if (!rst_in) begin
            m_q.delete();
            m_active = 1'b0; m_we = 1'b0; m_tag = TAG_NONE;
            m_val = '0; m_addr = '0; m_rd = '0;
            started = 1'b1;
        end else if (rdy_in) begin
            if (flush_in) begin
                m_q.delete();
                m_active = 1'b0; m_we = 1'b0; m_tag = TAG_NONE;
            end else begin
                m_full = (m_q.size() == DEPTH);
                if (m_q.size() > 0 && m_q[0].ready) begin
                    m_e = m_q.pop_front();
                    m_active = 1'b1; m_tag = m_e.tag; m_val = m_e.val;
                    m_addr = m_e.addr; m_rd = m_e.rd; m_we = (m_e.rd != 5'd0);
                end else begin
                    m_active = 1'b0; m_we = 1'b0; m_tag = TAG_NONE;
                end
                if (alu_valid && alu_tag != TAG_NONE)
                    foreach (m_q[i])
                        if (!m_q[i].ready && m_q[i].tag == alu_tag) begin
                            m_q[i].ready = 1'b1; m_q[i].val = alu_val;
                        end
                if (lsb_valid && lsb_tag != TAG_NONE)
                    foreach (m_q[i])
                        if (!m_q[i].ready && m_q[i].tag == lsb_tag) begin
                            m_q[i].ready = 1'b1; m_q[i].val = lsb_val;
                        end
                if (alloc_valid && !m_full)
                    m_q.push_back('{alloc_tag, alloc_rd, alloc_addr, 32'h0, 1'b0});
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk_in);
        if (started) begin
            chk("m.cdb_active", 32'(cdb_active), 32'(m_active));
            chk("m.cdb_tag",    32'(cdb_tag),    32'(m_tag));
            chk("m.cdb_val",    cdb_val,         m_val);
            chk("m.cdb_addr",   cdb_addr,        m_addr);
            chk("m.reg_we",     32'(reg_we),     32'(m_we));
            chk("m.reg_rd",     32'(reg_rd),     32'(m_rd));
            chk("m.reg_val",    reg_val,         m_val);
            chk("m.alloc_full", 32'(alloc_full), 32'(m_q.size() == DEPTH));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(negedge clk_in);
    endtask

    task automatic clear_in();
        alloc_valid = 1'b0; alu_valid = 1'b0; lsb_valid = 1'b0; flush_in = 1'b0;
    endtask

    task automatic do_alloc(input logic [3:0] tag, input logic [4:0] rd, input logic [31:0] addr);
        alloc_valid = 1'b1; alloc_tag = tag; alloc_rd = rd; alloc_addr = addr;
        cyc();
        alloc_valid = 1'b0;
    endtask

    task automatic do_alu(input logic [3:0] tag, input logic [31:0] val);
        alu_valid = 1'b1; alu_tag = tag; alu_val = val;
        cyc();
        alu_valid = 1'b0;
    endtask

    task automatic expect_bcast(input string name, input logic [3:0] tag, input logic [31:0] val,
                                input logic [31:0] addr, input logic we, input logic [4:0] rd);
        chk({name, ".cdb_active"}, 32'(cdb_active), 32'd1);
        chk({name, ".cdb_tag"},    32'(cdb_tag),    32'(tag));
        chk({name, ".cdb_val"},    cdb_val,         val);
        chk({name, ".cdb_addr"},   cdb_addr,        addr);
        chk({name, ".reg_we"},     32'(reg_we),     32'(we));
        chk({name, ".reg_rd"},     32'(reg_rd),     32'(rd));
        chk({name, ".reg_val"},    reg_val,         val);
    endtask

    task automatic expect_idle(input string name);
        chk({name, ".cdb_active"}, 32'(cdb_active), 32'd0);
        chk({name, ".reg_we"},     32'(reg_we),     32'd0);
        chk({name, ".cdb_tag"},    32'(cdb_tag),    32'(TAG_NONE));
    endtask

    task automatic expect_reset_outputs(input string name);
        expect_idle(name);
        chk({name, ".cdb_val"},    cdb_val,         32'd0);
        chk({name, ".cdb_addr"},   cdb_addr,        32'd0);
        chk({name, ".reg_rd"},     32'(reg_rd),     32'd0);
        chk({name, ".reg_val"},    reg_val,         32'd0);
        chk({name, ".alloc_full"}, 32'(alloc_full), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // ---------------- directed scenarios ----------------
    initial begin
        rst_in = 1'b0;
        repeat (2) cyc();
        expect_reset_outputs("reset");
        rst_in = 1'b1;
        cyc();

        // Single instruction: result two cycles after allocation.
        do_alloc(TAG_ADD1, 5'd5, 32'h100);
        cyc();
        do_alu(TAG_ADD1, 32'hDEAD);
        expect_idle("single.capture_edge");
        cyc();
        expect_bcast("single", TAG_ADD1, 32'hDEAD, 32'h100, 1'b1, 5'd5);
        cyc();
        expect_idle("single.after");
        chk("single.hold_val", cdb_val, 32'hDEAD);

        // Out-of-order results retire in program order.
        do_alloc(TAG_ADD1, 5'd1, 32'h200);
        do_alloc(TAG_ADD2, 5'd2, 32'h204);
        do_alloc(TAG_ADD3, 5'd3, 32'h208);
        do_alu(TAG_ADD3, 32'h3);
        do_alu(TAG_ADD1, 32'h1);
        expect_idle("ooo.wait");
        do_alu(TAG_ADD2, 32'h2);
        expect_bcast("ooo.1", TAG_ADD1, 32'h1, 32'h200, 1'b1, 5'd1);
        cyc();
        expect_bcast("ooo.2", TAG_ADD2, 32'h2, 32'h204, 1'b1, 5'd2);
        cyc();
        expect_bcast("ooo.3", TAG_ADD3, 32'h3, 32'h208, 1'b1, 5'd3);
        cyc();
        expect_idle("ooo.done");

        // Fill to full, drop when full, retire+alloc at full still rejects.
        for (int i = 0; i < DEPTH; i++)
            do_alloc(4'(i + 1), 5'(i + 1), 32'(32'h300 + 4 * i));
        chk("full.after8", 32'(alloc_full), 32'd1);
        do_alloc(4'd9, 5'd9, 32'h3F0);
        chk("full.drop9", 32'(alloc_full), 32'd1);
        do_alu(4'd1, 32'h31);
        do_alloc(4'd10, 5'd10, 32'h3F4);
        expect_bcast("full.retire1", 4'd1, 32'h31, 32'h300, 1'b1, 5'd1);
        chk("full.after_retire", 32'(alloc_full), 32'd0);
        for (int i = 2; i <= DEPTH; i++)
            do_alu(4'(i), 32'(32'h30 + i));
        cyc();
        expect_bcast("full.last", 4'd8, 32'h38, 32'h31C, 1'b1, 5'd8);
        do_alu(4'd9, 32'h99);
        do_alu(4'd10, 32'hAA);
        cyc();
        expect_idle("full.dropped_never_retire");

        // Pointer wrap over 20 alloc/retire pairs.
        for (int i = 0; i <= 20; i++) begin
            if (i < 20) begin
                alloc_valid = 1'b1;
                alloc_tag   = 4'((i % 3) + 1);
                alloc_rd    = 5'((i % 31) + 1);
                alloc_addr  = 32'(32'h400 + 4 * i);
            end else begin
                alloc_valid = 1'b0;
            end
            if (i > 0) begin
                alu_valid = 1'b1;
                alu_tag   = 4'(((i - 1) % 3) + 1);
                alu_val   = 32'(32'h1000 + i - 1);
            end
            cyc();
        end
        clear_in();
        cyc();
        expect_bcast("wrap.last", TAG_ADD2, 32'h1013, 32'h44C, 1'b1, 5'd20);
        cyc();
        expect_idle("wrap.done");

        // Both ports in one cycle, same tag on both, and rd=0.
        do_alloc(TAG_ADD2, 5'd2, 32'h700);
        do_alloc(TAG_LOAD1, 5'd4, 32'h704);
        alu_valid = 1'b1; alu_tag = TAG_ADD2;  alu_val = 32'd7;
        lsb_valid = 1'b1; lsb_tag = TAG_LOAD1; lsb_val = 32'd9;
        cyc();
        clear_in();
        cyc();
        expect_bcast("dual.alu", TAG_ADD2, 32'd7, 32'h700, 1'b1, 5'd2);
        cyc();
        expect_bcast("dual.lsb", TAG_LOAD1, 32'd9, 32'h704, 1'b1, 5'd4);
        do_alloc(TAG_ADD1, 5'd6, 32'h710);
        alu_valid = 1'b1; alu_tag = TAG_ADD1; alu_val = 32'h11;
        lsb_valid = 1'b1; lsb_tag = TAG_ADD1; lsb_val = 32'h22;
        cyc();
        clear_in();
        cyc();
        expect_bcast("same_tag", TAG_ADD1, 32'h11, 32'h710, 1'b1, 5'd6);
        do_alloc(TAG_ADD3, 5'd0, 32'h720);
        do_alu(TAG_ADD3, 32'h33);
        cyc();
        expect_bcast("rd0", TAG_ADD3, 32'h33, 32'h720, 1'b0, 5'd0);

        // Flush with three busy entries and a ready head.
        do_alloc(TAG_ADD1, 5'd1, 32'h800);
        do_alloc(TAG_ADD2, 5'd2, 32'h804);
        do_alloc(TAG_ADD3, 5'd3, 32'h808);
        do_alu(TAG_ADD1, 32'h81);
        flush_in = 1'b1;
        cyc();
        flush_in = 1'b0;
        expect_idle("flush.edge");
        chk("flush.alloc_full", 32'(alloc_full), 32'd0);
        do_alu(TAG_ADD2, 32'h82);
        cyc();
        expect_idle("flush.no_bcast");
        do_alloc(TAG_ADD1, 5'd9, 32'h900);
        do_alu(TAG_ADD1, 32'h99);
        cyc();
        expect_bcast("flush.new", TAG_ADD1, 32'h99, 32'h900, 1'b1, 5'd9);

        // Pause for 3 cycles right after a broadcast with the next head ready.
        do_alloc(TAG_ADD1, 5'd3, 32'h600);
        do_alloc(TAG_ADD2, 5'd4, 32'h604);
        alu_valid = 1'b1; alu_tag = TAG_ADD1; alu_val = 32'h66;
        lsb_valid = 1'b1; lsb_tag = TAG_ADD2; lsb_val = 32'h77;
        cyc();
        clear_in();
        cyc();
        expect_bcast("pause.first", TAG_ADD1, 32'h66, 32'h600, 1'b1, 5'd3);
        rdy_in = 1'b0;
        alloc_valid = 1'b1; alloc_tag = TAG_ADD3; alloc_rd = 5'd7; alloc_addr = 32'h608;
        for (int i = 0; i < 3; i++) begin
            cyc();
            expect_bcast("pause.frozen", TAG_ADD1, 32'h66, 32'h600, 1'b1, 5'd3);
        end
        clear_in();
        rdy_in = 1'b1;
        cyc();
        expect_bcast("pause.resume", TAG_ADD2, 32'h77, 32'h604, 1'b1, 5'd4);
        do_alu(TAG_ADD3, 32'h88);
        cyc();
        expect_idle("pause.alloc_ignored");

        // Reset mid-stream drops a ready entry without broadcasting it.
        do_alloc(TAG_ADD1, 5'd5, 32'hA00);
        do_alu(TAG_ADD1, 32'hAA);
        rst_in = 1'b0;
        cyc();
        expect_reset_outputs("midreset");
        rst_in = 1'b1;
        cyc();
        expect_idle("midreset.after");
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer for the Tomasulo core. It allocates one entry per issued instruction, keyed by the issuing station tag. It captures out-of-order results from the ALU reservation station and the load/store buffer, then retires entries strictly in program order. Each retirement drives exactly one CDB broadcast and the register-file write. The reservation stations consume its `cdb_*` outputs.

## Interface
- `DEPTH`, 8: entry count; power of two, ≥2.
- `TAG_W`, 4: station tag width; codes and `None` come from `macros.v`.
- `clk_in` input 1: clock.
- `rst_in` input 1: synchronous, active-low reset (low = reset).
- `rdy_in` input 1: global enable; low = pause.
- `flush_in` input 1: discard all entries (mispredict).
- `alloc_valid` input 1: issue request.
- `alloc_tag` input TAG_W: station tag of the issued instruction.
- `alloc_rd` input 5: destination register; 0 = no write-back.
- `alloc_addr` input 32: instruction PC.
- `alloc_full` output 1: combinational; `count == DEPTH`.
- `alu_valid` input 1: ALU result valid.
- `alu_tag` input TAG_W: ALU result tag.
- `alu_val` input 32: ALU result value.
- `lsb_valid` input 1: load/store result valid.
- `lsb_tag` input TAG_W: load/store result tag.
- `lsb_val` input 32: load/store result value.
- `cdb_active` output 1: one-cycle broadcast strobe.
- `cdb_tag` output TAG_W: tag being broadcast.
- `cdb_val` output 32: value being broadcast.
- `cdb_addr` output 32: PC of the retired instruction.
- `reg_we` output 1: register-file write enable.
- `reg_rd` output 5: register-file write index.
- `reg_val` output 32: register-file write data.

## Operation
- Entry fields: `busy`, `ready`, `tag`, `rd`, `addr`, `val`.
- `head` and `tail` are `log2(DEPTH)`-bit pointers, wrapping modulo DEPTH.
- `count` is `log2(DEPTH)+1` bits wide.
- **Allocation:**
  - Accepted when `alloc_valid && !alloc_full`.
  - Writes entry[tail] with busy=1 and ready=0, then increments tail and count.
  - `alloc_full` is evaluated before any same-cycle retirement. A request when full is dropped; the issuer stalls on `alloc_full`.
- **Result capture:**
  - For each valid result port, match the entry with busy=1, ready=0 and tag equal to the port tag. That entry sets ready=1 and stores the value.
  - At most one entry matches, because a station tag is reused only after its result is submitted.
  - A tag equal to `None`, or a tag with no match, is ignored.
  - If both ports name the same entry, ALU wins.
  - Both ports may update different entries in the same cycle.
- **Retirement (at most one per cycle):**
  - Fires when entry[head] has busy=1 and ready=1.
  - Next edge: `cdb_active`=1; `cdb_tag`, `cdb_val`, `cdb_addr` take the entry's fields.
  - `reg_we = (rd != 0)`, `reg_rd = rd`, `reg_val = val`.
  - The entry is cleared, head increments, count decrements.
  - When no retirement fires, next edge: `cdb_active`=0, `reg_we`=0, `cdb_tag`=`None`; data outputs hold.
- Simultaneous allocation and retirement: count is unchanged. This is legal even when count == DEPTH−1 or count == DEPTH (the full case still rejects the allocation).
- **Flush** (with `rdy_in` high):
  - Clears all busy/ready bits; head = tail = count = 0.
  - Next edge: `cdb_active`=0 and `reg_we`=0.
  - Any allocation, result or retirement in the same cycle is discarded.
  - Flush is priority over everything except reset.
- **`rdy_in` low:** all state and outputs hold; all inputs are ignored.

## Timing
- **Reset:** `rst_in` low at a rising edge clears every entry and pointer. Outputs after reset:
  - `cdb_active`=0, `reg_we`=0
  - `cdb_tag`=`None`
  - `cdb_val`=0, `cdb_addr`=0, `reg_rd`=0, `reg_val`=0
  - `alloc_full`=0
- Reset mid-operation drops all in-flight entries with no broadcast.
- Result-to-broadcast latency is 2 edges, for a result arriving in cycle t whose entry is at head:
  - Cycle t: captured at the edge ending t.
  - Cycle t+1: retirement is selected from registered state.
  - Cycle t+2: `cdb_*` are visible.
- An entry allocated in cycle t can capture a result no earlier than cycle t+1.
- Back-to-back ready entries retire on consecutive cycles.
- `alloc_full` is purely combinational from registered count; it has no input-to-output path.

## Structure
- `macros.v` holds:
  - tag codes `Add1..Add3`, the load/store tags and `None`;
  - new constant `ROB_DEPTH`.
- The tag-match logic (priority-free, one-hot per port) is the natural sub-module: `rob_tag_match`, instantiated twice (ALU port, LSB port). It outputs a match vector and a hit bit.
- Everything else is flat in `reorder_buffer`.

## Test plan
- **Single instruction:** allocate tag `Add1`, rd=5, addr=0x100. Two cycles later, ALU result `Add1`/0xDEAD. Expect:
  - `cdb_active` pulses once, 2 edges after the result;
  - `cdb_tag`=`Add1`, `cdb_val`=0xDEAD, `cdb_addr`=0x100;
  - `reg_we`=1, `reg_rd`=5.
- **Out-of-order results:** allocate `Add1`, `Add2`, `Add3`; results arrive in order `Add3`, `Add1`, `Add2`. Expect broadcasts in order `Add1`, `Add2`, `Add3`, on consecutive cycles after `Add2`'s result.
- **Fill to full:**
  - DEPTH=8: eight allocations make `alloc_full`=1; a ninth allocation is dropped and count stays 8.
  - Same-cycle retire plus allocate at full: the allocation is still rejected.
  - Pointers wrap correctly over 20 alloc/retire pairs.
- **Simultaneous ports:**
  - ALU `Add2`=7 with LSB `Load1`=9 in one cycle: both entries become ready.
  - Same tag on both ports: ALU value is kept.
  - rd=0 entry: broadcasts with `reg_we`=0.
- **Flush:** with 3 busy entries, one ready at head, assert `flush_in`. Expect:
  - no broadcast follows;
  - count=0 and `alloc_full`=0;
  - a new allocation retires normally afterwards.
- **Pause/reset:**
  - `rdy_in` low for 3 cycles while head is ready: outputs frozen; the broadcast occurs after `rdy_in` returns.
  - `rst_in` low mid-stream: all outputs reach their reset values on the next edge.
